// File: rtl/hpram_cmd_arbiter.sv
// hpram_cmd_arbiter
// Shares the HyperRAM command/data port between a write DMA and a read DMA.
// Whole bursts are granted round-robin, a fixed idle gap follows every burst,
// and a read that stops delivering beats is abandoned with a sticky flag.
// Every output is registered except the write data/mask, which pass the
// requester's same-cycle (first-word-fall-through) data through a gate.

module hpram_cmd_arbiter #(
    parameter int ADDR_WIDTH  = 22,
    parameter int DATA_WIDTH  = 32,
    parameter int BURST_WORDS = 16,
    parameter int GAP_CYCLES  = 4,
    parameter int TIMEOUT     = 255,
    localparam int MW         = DATA_WIDTH / 8
) (
    input  logic                  I_clk,
    input  logic                  I_rst_n,
    input  logic                  I_init_calib,
    input  logic                  I_wr_req,
    input  logic [ADDR_WIDTH-1:0] I_wr_addr,
    output logic                  O_wr_ack,
    output logic                  O_wr_data_req,
    input  logic [DATA_WIDTH-1:0] I_wr_data,
    input  logic [MW-1:0]         I_wr_mask,
    input  logic                  I_rd_req,
    input  logic [ADDR_WIDTH-1:0] I_rd_addr,
    output logic                  O_rd_ack,
    output logic                  O_rd_data_valid,
    output logic [DATA_WIDTH-1:0] O_rd_data,
    output logic                  O_cmd,
    output logic                  O_cmd_en,
    output logic [ADDR_WIDTH-1:0] O_addr,
    output logic [DATA_WIDTH-1:0] O_wr_data,
    output logic [MW-1:0]         O_data_mask,
    input  logic                  I_rd_data_valid,
    input  logic [DATA_WIDTH-1:0] I_rd_data,
    output logic                  O_busy,
    output logic                  O_timeout
);

    localparam int BW = $clog2(BURST_WORDS + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_WORDS - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_CMD,
        S_WR_DATA,
        S_RD_CMD,
        S_RD_WAIT,
        S_GAP
    } state_t;

    state_t                  state_q, state_d;
    logic [BW-1:0]           beat_q, beat_d;
    logic [GW-1:0]           gap_q, gap_d;
    logic [TW-1:0]           to_q, to_d;
    logic                    last_wr_q, last_wr_d;   // 1: last grant went to the writer
    logic                    cmd_q, cmd_d;
    logic                    cmd_en_q, cmd_en_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    wr_ack_q, wr_ack_d;
    logic                    rd_ack_q, rd_ack_d;
    logic                    wr_data_req_q, wr_data_req_d;
    logic                    rd_data_valid_q, rd_data_valid_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                    timeout_q, timeout_d;
    logic                    busy_q, busy_d;

    logic                    grant_wr;
    logic                    grant_rd;

    // Round-robin pick: on a tie the side that did not win last time goes next.
    always_comb begin
        grant_wr = I_wr_req && (!I_rd_req || !last_wr_q);
        grant_rd = I_rd_req && !grant_wr;
    end

    // Next-state and next-output computation; outputs are the values for the state being entered.
    always_comb begin
        state_d         = state_q;
        beat_d          = beat_q;
        gap_d           = gap_q;
        to_d            = to_q;
        last_wr_d       = last_wr_q;
        cmd_d           = cmd_q;
        addr_d          = addr_q;
        cmd_en_d        = 1'b0;
        wr_ack_d        = 1'b0;
        rd_ack_d        = 1'b0;
        wr_data_req_d   = 1'b0;
        rd_data_valid_d = 1'b0;
        rd_data_d       = rd_data_q;
        timeout_d       = timeout_q;

        if (!I_init_calib) begin
            // Lost calibration: drop whatever burst was running, it is never resumed.
            state_d = S_IDLE;
            beat_d  = '0;
            gap_d   = '0;
            to_d    = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_wr) begin
                        state_d       = S_WR_CMD;
                        last_wr_d     = 1'b1;
                        cmd_en_d      = 1'b1;
                        cmd_d         = 1'b1;
                        addr_d        = I_wr_addr;
                        wr_ack_d      = 1'b1;
                        wr_data_req_d = 1'b1;
                        beat_d        = '0;
                    end else if (grant_rd) begin
                        state_d   = S_RD_CMD;
                        last_wr_d = 1'b0;
                        cmd_en_d  = 1'b1;
                        cmd_d     = 1'b0;
                        addr_d    = I_rd_addr;
                        rd_ack_d  = 1'b1;
                        beat_d    = '0;
                        to_d      = '0;
                    end
                end
                S_WR_CMD: begin
                    // Beat 0 rides with the command; beat 1 follows immediately.
                    state_d       = S_WR_DATA;
                    beat_d        = BW'(1);
                    wr_data_req_d = 1'b1;
                end
                S_WR_DATA: begin
                    if (beat_q == BEAT_LAST) begin
                        state_d = S_GAP;
                        beat_d  = '0;
                        gap_d   = '0;
                    end else begin
                        beat_d        = beat_q + BW'(1);
                        wr_data_req_d = 1'b1;
                    end
                end
                S_RD_CMD: begin
                    state_d = S_RD_WAIT;
                    beat_d  = '0;
                    to_d    = '0;
                end
                S_RD_WAIT: begin
                    if (I_rd_data_valid) begin
                        rd_data_valid_d = 1'b1;
                        rd_data_d       = I_rd_data;
                        to_d            = '0;
                        if (beat_q == BEAT_LAST) begin
                            state_d = S_GAP;
                            beat_d  = '0;
                            gap_d   = '0;
                        end else begin
                            beat_d = beat_q + BW'(1);
                        end
                    end else if (to_q == TO_LAST) begin
                        // TIMEOUT consecutive cycles without a beat: give up on this read.
                        timeout_d = 1'b1;
                        state_d   = S_GAP;
                        beat_d    = '0;
                        gap_d     = '0;
                        to_d      = '0;
                    end else begin
                        to_d = to_q + TW'(1);
                    end
                end
                S_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_d = S_IDLE;
                        gap_d   = '0;
                    end else begin
                        gap_d = gap_q + GW'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    // State, counters and registered outputs; write wins the first tie after reset.
    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            state_q         <= S_IDLE;
            beat_q          <= '0;
            gap_q           <= '0;
            to_q            <= '0;
            last_wr_q       <= 1'b0;
            cmd_q           <= 1'b0;
            cmd_en_q        <= 1'b0;
            addr_q          <= '0;
            wr_ack_q        <= 1'b0;
            rd_ack_q        <= 1'b0;
            wr_data_req_q   <= 1'b0;
            rd_data_valid_q <= 1'b0;
            rd_data_q       <= '0;
            timeout_q       <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            beat_q          <= beat_d;
            gap_q           <= gap_d;
            to_q            <= to_d;
            last_wr_q       <= last_wr_d;
            cmd_q           <= cmd_d;
            cmd_en_q        <= cmd_en_d;
            addr_q          <= addr_d;
            wr_ack_q        <= wr_ack_d;
            rd_ack_q        <= rd_ack_d;
            wr_data_req_q   <= wr_data_req_d;
            rd_data_valid_q <= rd_data_valid_d;
            rd_data_q       <= rd_data_d;
            timeout_q       <= timeout_d;
            busy_q          <= busy_d;
        end
    end

    assign O_wr_ack        = wr_ack_q;
    assign O_wr_data_req   = wr_data_req_q;
    assign O_rd_ack        = rd_ack_q;
    assign O_rd_data_valid = rd_data_valid_q;
    assign O_rd_data       = rd_data_q;
    assign O_cmd           = cmd_q;
    assign O_cmd_en        = cmd_en_q;
    assign O_addr          = addr_q;
    assign O_busy          = busy_q;
    assign O_timeout       = timeout_q;
    assign O_wr_data       = wr_data_req_q ? I_wr_data : '0;
    assign O_data_mask     = wr_data_req_q ? I_wr_mask : '0;

endmodule

// File: tb/tb_hpram_cmd_arbiter.sv
// Bench for hpram_cmd_arbiter: requester/memory agents issue randomized traffic,
// expected commands and beats go into queues, and a negedge monitor pops and
// compares whatever the arbiter presents.

module tb_hpram_cmd_arbiter;

    localparam int AW = 22;
    localparam int DW = 32;
    localparam int BW = 16;
    localparam int GC = 4;
    localparam int TO = 255;
    localparam int MW = DW / 8;

    logic          I_clk;
    logic          I_rst_n;
    logic          I_init_calib;
    logic          I_wr_req;
    logic [AW-1:0] I_wr_addr;
    logic          O_wr_ack;
    logic          O_wr_data_req;
    logic [DW-1:0] I_wr_data;
    logic [MW-1:0] I_wr_mask;
    logic          I_rd_req;
    logic [AW-1:0] I_rd_addr;
    logic          O_rd_ack;
    logic          O_rd_data_valid;
    logic [DW-1:0] O_rd_data;
    logic          O_cmd;
    logic          O_cmd_en;
    logic [AW-1:0] O_addr;
    logic [DW-1:0] O_wr_data;
    logic [MW-1:0] O_data_mask;
    logic          I_rd_data_valid;
    logic [DW-1:0] I_rd_data;
    logic          O_busy;
    logic          O_timeout;

    hpram_cmd_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BURST_WORDS(BW),
        .GAP_CYCLES (GC),
        .TIMEOUT    (TO)
    ) dut (
        .I_clk          (I_clk),
        .I_rst_n        (I_rst_n),
        .I_init_calib   (I_init_calib),
        .I_wr_req       (I_wr_req),
        .I_wr_addr      (I_wr_addr),
        .O_wr_ack       (O_wr_ack),
        .O_wr_data_req  (O_wr_data_req),
        .I_wr_data      (I_wr_data),
        .I_wr_mask      (I_wr_mask),
        .I_rd_req       (I_rd_req),
        .I_rd_addr      (I_rd_addr),
        .O_rd_ack       (O_rd_ack),
        .O_rd_data_valid(O_rd_data_valid),
        .O_rd_data      (O_rd_data),
        .O_cmd          (O_cmd),
        .O_cmd_en       (O_cmd_en),
        .O_addr         (O_addr),
        .O_wr_data      (O_wr_data),
        .O_data_mask    (O_data_mask),
        .I_rd_data_valid(I_rd_data_valid),
        .I_rd_data      (I_rd_data),
        .O_busy         (O_busy),
        .O_timeout      (O_timeout)
    );

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    int cyc = 0;
    always @(posedge I_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    typedef struct { logic cmd; logic [AW-1:0] addr; } cmd_t;
    typedef struct { logic [DW-1:0] data; logic [MW-1:0] mask; } wbeat_t;
    typedef struct { logic [DW-1:0] data; int cyc; } rbeat_t;

    cmd_t   exp_cmd[$];
    wbeat_t wsrc[$];
    wbeat_t exp_wbeat[$];
    rbeat_t exp_rbeat[$];

    // Reference arbitration: alternate on ties, write first after reset.
    bit model_last_wr = 1'b0;
    function automatic bit model_grant(input bit w, input bit r);
        bit g;
        g = w && (!r || !model_last_wr);
        model_last_wr = g;
        return g;
    endfunction

    task automatic expect_cmd(input bit is_wr, input logic [AW-1:0] addr);
        cmd_t c;
        c.cmd  = is_wr;
        c.addr = addr;
        exp_cmd.push_back(c);
    endtask

    // Write requester FIFO (first word falls through): pop on each consumed beat.
    initial begin
        I_wr_data = '0;
        I_wr_mask = '0;
        forever begin
            @(negedge I_clk);
            if (O_wr_data_req && wsrc.size() > 0) void'(wsrc.pop_front());
            #1;
            if (wsrc.size() > 0) begin
                I_wr_data = wsrc[0].data;
                I_wr_mask = wsrc[0].mask;
            end else begin
                I_wr_data = '0;
                I_wr_mask = '0;
            end
        end
    end

    // Monitor: every presented command/beat must match the head of its queue.
    bit     mon_en = 1'b0;
    int     last_wr_cmd_cyc = -1000;
    cmd_t   mc;
    wbeat_t mw;
    rbeat_t mr;
    initial begin
        forever begin
            @(negedge I_clk);
            if (mon_en) begin
                if (O_cmd_en) begin
                    chk("cmd_expected", exp_cmd.size() > 0, 1);
                    if (exp_cmd.size() > 0) begin
                        mc = exp_cmd.pop_front();
                        $display("cmd  cyc=%0d %s addr=0x%0h", cyc, O_cmd ? "WR" : "RD", O_addr);
                        chk("cmd_dir", O_cmd, mc.cmd);
                        chk("cmd_addr", O_addr, mc.addr);
                    end
                    chk("wr_ack_with_cmd", O_wr_ack, O_cmd);
                    chk("rd_ack_with_cmd", O_rd_ack, !O_cmd);
                    if (last_wr_cmd_cyc >= 0)
                        chk("cmd_spacing_after_write", (cyc - last_wr_cmd_cyc) >= (BW + GC + 1), 1);
                    last_wr_cmd_cyc = O_cmd ? cyc : -1000;
                end else begin
                    chk("no_stray_ack", {O_wr_ack, O_rd_ack}, 0);
                end
                if (O_wr_data_req) begin
                    chk("wbeat_expected", exp_wbeat.size() > 0, 1);
                    if (exp_wbeat.size() > 0) begin
                        mw = exp_wbeat.pop_front();
                        chk("wr_data", O_wr_data, mw.data);
                        chk("wr_mask", O_data_mask, mw.mask);
                    end
                end else begin
                    chk("wr_bus_idle", {O_wr_data, O_data_mask}, 0);
                end
                if (O_rd_data_valid) begin
                    chk("rbeat_expected", exp_rbeat.size() > 0, 1);
                    if (exp_rbeat.size() > 0) begin
                        mr = exp_rbeat.pop_front();
                        $display("rbeat cyc=%0d data=0x%08h", cyc, O_rd_data);
                        chk("rd_data", O_rd_data, mr.data);
                        chk("rd_latency", cyc, mr.cyc);
                    end
                end
            end
        end
    end

    task automatic wait_ack(input bit is_wr, output int ack_cyc);
        bit got;
        got     = 1'b0;
        ack_cyc = 0;
        for (int t = 0; t < 600 && !got; t++) begin
            @(negedge I_clk);
            if (is_wr ? O_wr_ack : O_rd_ack) begin
                got     = 1'b1;
                ack_cyc = cyc;
            end
        end
        chk(is_wr ? "wr_ack_seen" : "rd_ack_seen", got, 1);
        if (is_wr) I_wr_req = 1'b0;
        else       I_rd_req = 1'b0;
    endtask

    task automatic push_wr_words(input int base, input bit rnd);
        wbeat_t b;
        for (int i = 0; i < BW; i++) begin
            b.data = rnd ? DW'($urandom) : DW'(base + i);
            b.mask = rnd ? MW'($urandom) : '1;
            wsrc.push_back(b);
            exp_wbeat.push_back(b);
        end
    endtask

    task automatic wr_burst(input logic [AW-1:0] addr, input int base, input bit rnd, output int ack_cyc);
        push_wr_words(base, rnd);
        @(negedge I_clk);
        #2;
        I_wr_addr = addr;
        I_wr_req  = 1'b1;
        wait_ack(1'b1, ack_cyc);
    endtask

    int last_rbeat_cyc = 0;

    task automatic rd_beats(input int nbeats, input int maxgap, input int longgap_at);
        rbeat_t e;
        int     gap;
        for (int b = 0; b < nbeats; b++) begin
            gap = (b == longgap_at) ? 250 : int'($urandom_range(maxgap, 0));
            repeat (gap) begin
                @(posedge I_clk);
                #1;
                I_rd_data_valid = 1'b0;
            end
            @(posedge I_clk);
            #1;
            e.data          = DW'($urandom);
            e.cyc           = cyc + 1;
            I_rd_data_valid = 1'b1;
            I_rd_data       = e.data;
            last_rbeat_cyc  = cyc;
            exp_rbeat.push_back(e);
        end
        @(posedge I_clk);
        #1;
        I_rd_data_valid = 1'b0;
    endtask

    task automatic rd_burst(input logic [AW-1:0] addr, input int nbeats, input int maxgap, input int longgap_at);
        int ac;
        @(negedge I_clk);
        #2;
        I_rd_addr = addr;
        I_rd_req  = 1'b1;
        wait_ack(1'b0, ac);
        rd_beats(nbeats, maxgap, longgap_at);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_strobes"}, {O_busy, O_cmd_en, O_cmd, O_wr_ack, O_rd_ack,
                                O_wr_data_req, O_rd_data_valid, O_timeout}, 0);
        chk({tag, "_addr"}, O_addr, 0);
        chk({tag, "_rd_data"}, O_rd_data, 0);
        chk({tag, "_wr_bus"}, {O_wr_data, O_data_mask}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int c, seen, dw, dr;
    logic [AW-1:0] wa[2];
    logic [AW-1:0] ra[2];
    logic [AW-1:0] tmp_addr;

    initial begin
        I_rst_n = 1'b0; I_init_calib = 1'b1;
        I_wr_req = 1'b0; I_wr_addr = '0;
        I_rd_req = 1'b0; I_rd_addr = '0;
        I_rd_data_valid = 1'b0; I_rd_data = '0;

        // Reset values
        repeat (3) @(posedge I_clk);
        @(negedge I_clk);
        check_all_zero("reset");
        @(posedge I_clk); #1;
        I_rst_n = 1'b1;
        mon_en  = 1'b1;

        // Single write burst, data 0..15
        expect_cmd(model_grant(1, 0), 22'h000100);
        wr_burst(22'h000100, 0, 1'b0, c);
        repeat (BW + GC - 1) @(negedge I_clk);
        chk("wr_gap_busy", {O_busy, O_wr_data_req, O_cmd_en}, 3'b100);
        @(negedge I_clk);
        chk("wr_back_idle", O_busy, 0);
        chk("wr_beats_drained", exp_wbeat.size(), 0);
        $display("test write-only done cyc=%0d", cyc);

        // Single read burst with random beat gaps, one of them 250 cycles
        expect_cmd(model_grant(0, 1), 22'h3FFF00);
        rd_burst(22'h3FFF00, BW, 40, 7);
        repeat (GC + 3) @(negedge I_clk);
        chk("rd_beats_drained", exp_rbeat.size(), 0);
        chk("rd_no_timeout", O_timeout, 0);
        chk("rd_back_idle", O_busy, 0);
        $display("test read-only done cyc=%0d", cyc);

        // Both requesters always pending: alternating grants
        for (int i = 0; i < 2; i++) begin
            wa[i] = AW'($urandom);
            ra[i] = AW'($urandom);
        end
        begin
            int wi, ri;
            wi = 0; ri = 0;
            for (int k = 0; k < 4; k++) begin
                if (model_grant(1, 1)) begin expect_cmd(1'b1, wa[wi]); wi++; end
                else                   begin expect_cmd(1'b0, ra[ri]); ri++; end
            end
        end
        fork
            begin
                for (int i = 0; i < 2; i++) wr_burst(wa[i], 0, 1'b1, dw);
            end
            begin
                for (int i = 0; i < 2; i++) rd_burst(ra[i], BW, 6, -1);
            end
        join
        repeat (BW + GC + 4) @(negedge I_clk);
        chk("rr_cmds_drained", exp_cmd.size(), 0);
        chk("rr_beats_drained", exp_wbeat.size() + exp_rbeat.size(), 0);
        $display("test round-robin done cyc=%0d", cyc);

        // Read that stalls after 3 beats times out
        tmp_addr = AW'($urandom);
        expect_cmd(model_grant(0, 1), tmp_addr);
        rd_burst(tmp_addr, 3, 5, -1);
        seen = -1;
        for (int t = 0; t < TO + 50 && seen < 0; t++) begin
            @(negedge I_clk);
            if (O_timeout) seen = cyc;
        end
        chk("timeout_set", O_timeout, 1);
        chk("timeout_delay", seen - last_rbeat_cyc, TO + 1);
        repeat (GC - 1) @(negedge I_clk);
        chk("timeout_gap_busy", O_busy, 1);
        @(negedge I_clk);
        chk("timeout_back_idle", O_busy, 0);
        tmp_addr = AW'($urandom);
        expect_cmd(model_grant(1, 0), tmp_addr);
        wr_burst(tmp_addr, 0, 1'b1, c);
        repeat (BW + GC + 2) @(negedge I_clk);
        chk("timeout_sticky", O_timeout, 1);
        chk("post_timeout_wr_drained", exp_wbeat.size(), 0);
        $display("test timeout done cyc=%0d", cyc);

        // Calibration low blocks grants; dropping it mid-burst aborts
        @(negedge I_clk); #2;
        I_init_calib = 1'b0;
        I_wr_addr = AW'($urandom); I_wr_req = 1'b1;
        I_rd_addr = AW'($urandom); I_rd_req = 1'b1;
        repeat (20) @(negedge I_clk);
        chk("nocal_idle", {O_busy, O_cmd_en, O_wr_ack, O_rd_ack}, 0);
        I_rd_req = 1'b0;
        push_wr_words(0, 1'b1);
        expect_cmd(model_grant(1, 0), I_wr_addr);
        @(negedge I_clk); #2;
        I_init_calib = 1'b1;
        wait_ack(1'b1, c);
        repeat (5) @(posedge I_clk);
        #1;
        I_init_calib = 1'b0;
        last_wr_cmd_cyc = -1000;
        @(negedge I_clk);
        @(negedge I_clk);
        chk("abort_no_wr_req", O_wr_data_req, 0);
        chk("abort_idle", O_busy, 0);
        #2;
        wsrc.delete();
        exp_wbeat.delete();
        @(posedge I_clk); #1;
        I_init_calib = 1'b1;
        tmp_addr = AW'($urandom);
        expect_cmd(model_grant(1, 0), tmp_addr);
        wr_burst(tmp_addr, 0, 1'b1, c);
        repeat (BW + GC + 2) @(negedge I_clk);
        chk("regrant_wr_drained", exp_wbeat.size(), 0);
        $display("test calibration done cyc=%0d", cyc);

        // Reset in the middle of a read burst
        tmp_addr = AW'($urandom);
        expect_cmd(model_grant(0, 1), tmp_addr);
        @(negedge I_clk); #2;
        I_rd_addr = tmp_addr; I_rd_req = 1'b1;
        wait_ack(1'b0, c);
        rd_beats(2, 2, -1);
        @(posedge I_clk); #1;
        I_rst_n = 1'b0;
        @(posedge I_clk); #1;
        I_rst_n = 1'b1;
        model_last_wr = 1'b0;
        last_wr_cmd_cyc = -1000;
        @(negedge I_clk);
        check_all_zero("midreset");
        chk("midreset_queues_drained", exp_rbeat.size() + exp_cmd.size(), 0);
        wa[0] = AW'($urandom);
        ra[0] = AW'($urandom);
        for (int k = 0; k < 2; k++) begin
            if (model_grant(1, 1)) expect_cmd(1'b1, wa[0]);
            else                   expect_cmd(1'b0, ra[0]);
        end
        fork
            wr_burst(wa[0], 0, 1'b1, dw);
            rd_burst(ra[0], BW, 3, -1);
        join
        repeat (GC + 4) @(negedge I_clk);
        chk("final_cmds_drained", exp_cmd.size(), 0);
        chk("final_beats_drained", exp_wbeat.size() + exp_rbeat.size(), 0);
        chk("final_no_timeout", O_timeout, 0);
        $display("test reset-tie done cyc=%0d", cyc);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/hpram_cmd_arbiter.md
Name: hpram_cmd_arbiter

Overview:
Shares the single HyperRAM memory-interface command/data port between one write requester (frame-buffer input DMA) and one read requester (frame-buffer output DMA). Grants whole bursts round-robin and drives cmd/cmd_en/addr/wr_data/data_mask. Returns read data to the read requester, enforces an inter-command gap, and flags read timeouts. Sits between the frame-buffer DMA engines and the HyperRAM memory interface, in the memory interface's output clock domain.

Parameters:
ADDR_WIDTH, 22, memory word address width
DATA_WIDTH, 32, data bus width; mask width MW = DATA_WIDTH/8
BURST_WORDS, 16, data beats per command (>=2)
GAP_CYCLES, 4, idle cycles after each burst before the next grant (>=1)
TIMEOUT, 255, max cycles between read beats before abort

Ports:
I_clk  in  1  memory-interface output clock; only clock
I_rst_n  in  1  synchronous active-low reset
I_init_calib  in  1  memory calibration done; grants only while high
I_wr_req  in  1  write burst request; held until O_wr_ack
I_wr_addr  in  ADDR_WIDTH  write burst start address; stable while I_wr_req
O_wr_ack  out  1  1-cycle pulse: write command issued
O_wr_data_req  out  1  high in each write beat cycle; requester supplies data same cycle (FWFT)
I_wr_data  in  DATA_WIDTH  write beat data
I_wr_mask  in  MW  write beat byte mask
I_rd_req  in  1  read burst request; held until O_rd_ack
I_rd_addr  in  ADDR_WIDTH  read burst start address
O_rd_ack  out  1  1-cycle pulse: read command issued
O_rd_data_valid  out  1  registered copy of accepted read beat valid
O_rd_data  out  DATA_WIDTH  registered read beat data
O_cmd  out  1  1=write, 0=read
O_cmd_en  out  1  command strobe, 1 cycle per burst
O_addr  out  ADDR_WIDTH  command address
O_wr_data  out  DATA_WIDTH  I_wr_data when O_wr_data_req, else 0
O_data_mask  out  MW  I_wr_mask when O_wr_data_req, else 0
I_rd_data_valid  in  1  read beat valid from memory interface
I_rd_data  in  DATA_WIDTH  read beat data
O_busy  out  1  high in any state other than IDLE
O_timeout  out  1  sticky read-timeout flag; cleared only by reset

Behaviour:
- Reset (I_rst_n low at posedge): state IDLE, all outputs 0, beat/gap/timeout counters 0, last_grant=READ (so write wins the first tie).
- States: IDLE, WR_CMD, WR_DATA, RD_CMD, RD_WAIT, GAP.
- IDLE: I_init_calib low -> stay. Only one request -> grant it. Both requesting -> grant the side opposite last_grant. Grant updates last_grant. Request to grant state: 1 cycle.
- WR_CMD (1 cycle): O_cmd_en=1, O_cmd=1, O_addr=I_wr_addr, O_wr_ack=1, O_wr_data_req=1 (beat 0) -> WR_DATA.
- WR_DATA: O_wr_data_req=1 for beats 1..BURST_WORDS-1 on consecutive cycles, no stalls -> GAP after last beat.
- RD_CMD (1 cycle): O_cmd_en=1, O_cmd=0, O_addr=I_rd_addr, O_rd_ack=1 -> RD_WAIT.
- RD_WAIT: each I_rd_data_valid increments the beat count and is forwarded with 1-cycle latency on O_rd_data_valid/O_rd_data. After BURST_WORDS beats -> GAP. A timeout counter resets on each beat. If TIMEOUT cycles pass with no beat, set O_timeout and go to GAP.
- I_rd_data_valid outside RD_WAIT is ignored (no forward). Beats beyond BURST_WORDS are impossible because the state leaves RD_WAIT.
- GAP: all strobes 0 for exactly GAP_CYCLES cycles -> IDLE.
- O_addr, O_cmd hold their last value outside command cycles; O_cmd_en is the sole qualifier.
- I_init_calib falling in any state: next cycle -> IDLE, counters cleared, no ack/strobe. O_timeout is kept. An aborted burst is not resumed.
- Synchronous reset mid-burst: same as the reset values above; the memory interface is reset by the same source.
- Maximum grant rate: one burst per (BURST_WORDS+GAP_CYCLES+1) cycles for writes.

Test Plan:
- Write only, addr 0x000100, data 0..15 -> O_cmd_en one pulse with O_cmd=1 and O_addr=0x000100. O_wr_data_req high 16 consecutive cycles carrying 0..15. Then 4 idle cycles, then IDLE.
- Read only, addr 0x3FFF00; memory returns 16 beats with random gaps (<255) -> 16 O_rd_data_valid pulses, each 1 cycle after its input, with data matching. O_timeout stays 0.
- Both requests held continuously for 4 bursts -> grant order W,R,W,R. No two cmd_en pulses closer than the gap rule allows.
- Read with only 3 beats returned -> after 255 idle cycles O_timeout=1, GAP, IDLE. A later write proceeds normally and O_timeout stays 1.
- I_init_calib low with requests pending -> no cmd_en and no acks. Drop I_init_calib at write beat 5 -> IDLE next cycle, O_wr_data_req=0. Raising it regrants starting at WR_CMD.
- Assert I_rst_n=0 for 1 cycle mid-RD_WAIT -> all outputs 0 at the next edge. O_timeout cleared. First tie after reset goes to write.
